// File: rtl/riscv_perf_pkg.sv
// Shared types and helpers for the riscv_perf_monitor block.
package riscv_perf_pkg;

  typedef enum logic [1:0] {PM_IDLE, PM_RUN, PM_DONE} pm_state_t;

  // Index of the free-running cycle counter within the counter bank
  localparam int unsigned PM_IDX_CYCLE = 0;

  // Width of a read index able to address cycle counter plus num_evt event counters
  function automatic int unsigned pm_idx_w(input int unsigned num_evt);
    return (num_evt < 1) ? 1 : $clog2(num_evt + 1);
  endfunction

endpackage

// File: rtl/riscv_perf_ctr.sv
// Single performance counter with clear, increment and sticky overflow flag.
// RISCV_PERF_SATURATE_EN: saturate at all-ones instead of wrapping.
module riscv_perf_ctr #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear dominates increment; overflow stays set until clear or reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
`ifdef RISCV_PERF_SATURATE_EN
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (cnt == CNT_MAX - 1'b1) ovf <= 1'b1;
`else
      cnt <= cnt + 1'b1;
      if (cnt == CNT_MAX) ovf <= 1'b1;
`endif
    end
  end

endmodule

// File: rtl/riscv_perf_monitor.sv
// Cycle/event performance monitor with run-length watchdog and snapshot read port.
// RISCV_PERF_SATURATE_EN: counters saturate, and a saturating cycle counter ends the run.
module riscv_perf_monitor
  import riscv_perf_pkg::*;
#(
  parameter int unsigned NUM_EVT        = 4,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 500
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start_i,
  input  logic                           stop_i,
  input  logic                           clear_i,
  input  logic [NUM_EVT-1:0]             evt_i,
  input  logic                           snap_i,
  input  logic                           rd_req_i,
  input  logic [pm_idx_w(NUM_EVT)-1:0]   rd_idx_i,
  output logic                           rd_valid_o,
  output logic [CNT_W-1:0]               rd_data_o,
  output logic                           running_o,
  output logic                           done_o,
  output logic [NUM_EVT:0]               ovf_o
);

  localparam int unsigned NCNT  = NUM_EVT + 1;
  localparam int unsigned IDX_W = pm_idx_w(NUM_EVT);
  // The run ends on the cycle that takes the cycle counter from TO_LAST to TO_LAST+1
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
`ifdef RISCV_PERF_SATURATE_EN
  localparam logic [CNT_W-1:0] SAT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
`endif

  pm_state_t        state;
  logic [CNT_W-1:0] live   [NCNT];
  logic [CNT_W-1:0] shadow [NCNT];
  logic [NCNT-1:0]  inc;
  logic             end_hit;
  logic [CNT_W-1:0] rd_sel;

  // Counting only happens in RUN; running_o mirrors state == PM_RUN
  assign inc = {evt_i & {NUM_EVT{running_o}}, running_o};

  for (genvar g = 0; g < NCNT; g++) begin : g_ctr
    riscv_perf_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (inc[g]),
      .clr     (clear_i),
      .cnt     (live[g]),
      .ovf     (ovf_o[g])
    );
  end

  // Detect the last counting cycle of a run (timeout or cycle-counter saturation)
  always_comb begin
    end_hit = 1'b0;
    if ((TIMEOUT_CYCLES != 0) && (live[PM_IDX_CYCLE] >= TO_LAST)) end_hit = 1'b1;
`ifdef RISCV_PERF_SATURATE_EN
    if (live[PM_IDX_CYCLE] >= SAT_LAST) end_hit = 1'b1;
`endif
  end

  // Run-control FSM; priority clear > stop > end-of-run > start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PM_IDLE;
      running_o <= 1'b0;
      done_o    <= 1'b0;
    end else if (clear_i) begin
      state     <= PM_IDLE;
      running_o <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      case (state)
        PM_IDLE: if (start_i) begin
          state     <= PM_RUN;
          running_o <= 1'b1;
        end
        PM_RUN: if (stop_i) begin
          state     <= PM_IDLE;
          running_o <= 1'b0;
        end else if (end_hit) begin
          state     <= PM_DONE;
          running_o <= 1'b0;
          done_o    <= 1'b1;
        end
        PM_DONE: state <= PM_DONE;
        default: begin
          state     <= PM_IDLE;
          running_o <= 1'b0;
          done_o    <= 1'b0;
        end
      endcase
    end
  end

  // Shadow mux; out-of-range indices read as zero
  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < NCNT; i++) begin
      if (rd_idx_i == IDX_W'(i)) rd_sel = shadow[i];
    end
  end

  // Snapshot bank and registered read port; a same-cycle snap is not visible to the read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NCNT; i++) shadow[i] <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      if (snap_i) begin
        for (int unsigned i = 0; i < NCNT; i++) shadow[i] <= live[i];
      end
      rd_valid_o <= rd_req_i;
      if (rd_req_i) rd_data_o <= rd_sel;
    end
  end

endmodule
